// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush scheduler with stale-fetch discard
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_wait,
  input  logic             if_inflight,
  input  logic             if_data_ok,
  input  logic             load_use,
  input  logic             ex_busy,
  input  logic             mem_wait,
  input  logic             exc_flush,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_wb_stall,
  output logic             if_id_refresh,
  output logic             id_ex_refresh,
  output logic             ex_wb_refresh,
  output logic             discard_fetch,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, DISCARD = 1'b1} state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_wb_stall   = 1'b0;
    if_id_refresh = 1'b0;
    id_ex_refresh = 1'b0;
    ex_wb_refresh = 1'b0;
    discard_fetch = 1'b0;
    // The stale return is dropped on arrival whatever else the pipe is doing.
    if (state_q == DISCARD && if_data_ok) state_d = RUN;
    if (!resetn) begin
      if_id_refresh = 1'b1;
      id_ex_refresh = 1'b1;
      ex_wb_refresh = 1'b1;
    end else if (mem_wait) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_wb_stall   = 1'b1;
      discard_fetch = (state_q == DISCARD) && if_data_ok;
    end else if (exc_flush) begin
      if_id_refresh = 1'b1;
      id_ex_refresh = 1'b1;
      ex_wb_refresh = 1'b1;
      discard_fetch = if_data_ok;
      if (if_inflight && !if_data_ok) state_d = DISCARD;
    end else if (state_q == DISCARD) begin
      pc_stall      = 1'b1;
      if_id_refresh = 1'b1;
      discard_fetch = if_data_ok;
    end else if (ex_busy) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_wb_refresh = 1'b1;
    end else if (load_use) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_refresh = 1'b1;
    end else if (if_wait) begin
      pc_stall      = 1'b1;
      if_id_refresh = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic             flush_acc;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  assign flush_acc      = resetn && !mem_wait && exc_flush;
  assign stall_cycles_d = pc_stall  ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  assign flush_count_d  = flush_acc ? flush_count_q + CNT_W'(1)  : flush_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
